iter_alu: RTL
=============

Name: iter_alu

Overview:
- Multi-cycle execute unit that consumes the 4-bit ALUop codes produced by instruction decode (encodings from the `ALU_*` macros in ALUop.vh).
- Single-cycle logic ops; iterative shifter for SLL/SRL/SRA to save area on the FPGA datapath.
- Valid/ready handshake on both sides; sits between decode/operand-select and writeback in the multi-cycle datapath variant.

Parameters:
- WIDTH, 32, operand/result width in bits; power of 2, minimum 8.
- SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation this cycle.
- ALUop  input  4  operation code (`ALU_*` encoding).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; low log2(WIDTH) bits are the shift amount for shifts.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- illegal  output  1  registered; high with out_valid when ALUop was `ALU_XXX` or unassigned.

Behaviour:
- Reset (rst=1 at edge): state IDLE, out_valid=0, result=0, illegal=0. in_ready=0 during any cycle rst is high. rst mid-shift or mid-DONE discards the operation with no output.
- FSM states: IDLE, SHIFT, DONE.
- in_ready=1 only in IDLE with rst=0. Accept occurs when in_valid && in_ready; A, B, ALUop are captured at that edge. Inputs are ignored at all other times.
- IDLE accept, non-shift op: compute and register result; next state DONE. out_valid is high the cycle after accept (latency 1).
  - ADD: A+B mod 2^WIDTH.
  - SUB: A-B mod 2^WIDTH.
  - AND, OR, XOR: bitwise.
  - SLT: signed A<B gives 1, else 0.
  - SLTU: unsigned compare, same result encoding.
  - COPY_B: result=B.
  - XXX/unassigned: result=0, illegal=1.
- IDLE accept, shift op (SLL/SRL/SRA):
  - Latch A into the working register and amt=B[log2(WIDTH)-1:0].
  - amt==0: next state DONE with result=A (latency 1).
  - Otherwise next state SHIFT.
- SHIFT, each cycle: shift the working register by min(SHIFT_STEP, amt) and subtract that from amt.
  - SRA fills with the sign bit of the original A; SLL and SRL fill with zeros.
  - When amt reaches 0, move to DONE with result=working value.
  - Shift latency = 1 + ceil(amt/SHIFT_STEP) cycles from accept to out_valid.
- DONE: out_valid=1; result and illegal stay stable until out_ready=1. At that edge out_valid drops and state returns to IDLE. The next accept is possible the cycle after.
- out_ready is ignored outside DONE.
- illegal is cleared on every new accept.

Optional Feature:
- Macro ITER_ALU_BYPASS_EN.
- Defined: in_ready = (IDLE || (DONE && out_ready)) && !rst. An operation accepted in the same cycle the result drains starts immediately, giving back-to-back single-cycle ops at 1 op/cycle.
- Undefined: in_ready only in IDLE; minimum 2 cycles per operation.

Test Plan:
- Reset then idle: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, result=0 throughout; first cycle after rst low, in_ready=1.
- ADD/SUB wrap: A=0xFFFFFFFF, B=1, ADD -> result=0x00000000 one cycle after accept. SUB with A=0, B=1 -> 0xFFFFFFFF. illegal=0 for both.
- SLT vs SLTU: A=0xFFFFFFFF, B=1 -> SLT=1, SLTU=0. COPY_B with B=0x12345000 -> 0x12345000.
- Shifts at SHIFT_STEP=1:
  - SRA, A=0x80000000, B=31 -> result=0xFFFFFFFF, out_valid 32 cycles after accept.
  - SRL, same operands -> 0x00000001.
  - SLL, A=1, B=0 -> 1 at latency 1.
  - Repeat with SHIFT_STEP=4: SRA amt 31 -> latency 9.
- Backpressure and illegal: ALU_XXX accepted, out_ready=0 for 5 cycles -> out_valid=1, illegal=1, result=0 held stable, in_ready=0. A new in_valid during that time is not accepted.
- Reset mid-shift plus bypass: assert rst during the SHIFT of SLL amt 20 -> no out_valid afterwards, IDLE next cycle. With ITER_ALU_BYPASS_EN defined, a stream of 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle execute unit with single-cycle logic ops and an iterative shifter.
// Optional ITER_ALU_BYPASS_EN: accept a new op in the same cycle the result drains.
module iter_alu #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    localparam int AW = $clog2(WIDTH);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_CPYB = 4'd10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [AW:0] STEP = (AW+1)'(SHIFT_STEP);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [AW-1:0]    amt;
    logic [3:0]       op_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             is_shift;
    logic [AW:0]      amt_ext;
    logic [AW:0]      step;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

`ifdef ITER_ALU_BYPASS_EN
    assign in_ready = !rst &&
        (state == S_IDLE || (state == S_DONE && out_ready));
`else
    assign in_ready = !rst && (state == S_IDLE);
`endif

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (ALUop)
            ALU_ADD:  alu_res = A + B;
            ALU_SUB:  alu_res = A - B;
            ALU_AND:  alu_res = A & B;
            ALU_OR:   alu_res = A | B;
            ALU_XOR:  alu_res = A ^ B;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                 $signed(A) < $signed(B)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
            ALU_CPYB: alu_res = B;
            ALU_SLL, ALU_SRL, ALU_SRA: is_shift = 1'b1;
            default:  alu_ill = 1'b1;
        endcase
    end

    // The final partial step shifts only the remaining amount.
    always_comb begin
        amt_ext = {1'b0, amt};
        step    = (amt_ext < STEP) ? amt_ext : STEP;
        case (op_q)
            ALU_SRL: shifted = work >> step;
            ALU_SRA: shifted = $signed(work) >>> step;
            default: shifted = work << step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            result  <= '0;
            illegal <= 1'b0;
            work    <= '0;
            amt     <= '0;
            op_q    <= ALU_ADD;
        end else begin
            case (state)
                S_SHIFT: begin
                    work <= shifted;
                    amt  <= amt - step[AW-1:0];
                    if (amt_ext == step) begin
                        result <= shifted;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // An accept in DONE (bypass) overrides the drain to IDLE.
            if (accept) begin
                illegal <= alu_ill;
                op_q    <= ALUop;
                if (is_shift) begin
                    work <= A;
                    amt  <= B[AW-1:0];
                    if (B[AW-1:0] == '0) begin
                        result <= A;
                        state  <= S_DONE;
                    end else begin
                        state <= S_SHIFT;
                    end
                end else begin
                    result <= alu_res;
                    state  <= S_DONE;
                end
            end
        end
    end

endmodule
